// File: rtl/layer_sequencer.sv
// Layer scheduler for the 4-unit network: start driver, collect unit results, store them, repeat per layer.
// Optional per-phase watchdog is compiled in with `define LAYER_SEQ_TIMEOUT_EN.
module layer_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int TIMEOUT    = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       abort,
  output logic       drv_start,
  output logic [1:0] drv_layer,
  input  logic       drv_done,
  input  logic [3:0] unit_valid,
  output logic       act_we,
  output logic [1:0] act_sel,
  output logic [1:0] act_layer,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_DRV, WAIT_UNITS, STORE, NEXT, DONE, ERR
  } state_t;

  localparam logic [1:0] LAST_LAYER = 2'(NUM_LAYERS - 1);

  state_t     state;
  logic [1:0] layer;
  logic [1:0] sidx;
  logic [3:0] vmask;
  logic [3:0] vmask_nxt;

  // Pulses landing in the same cycle as the completion check still count.
  assign vmask_nxt = vmask | unit_valid;

`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wdog;
  logic        err_q;
  logic        wdog_hit;

  assign wdog_hit = (wdog == WDOG_LAST);
  assign error    = err_q;
`else
  assign error = 1'b0;
`endif

  // NOTE: every register here is updated with <= so all branches see the pre-edge values of
  // state, layer and sidx; mixing in blocking assignments would make results order-dependent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      layer     <= '0;
      sidx      <= '0;
      vmask     <= '0;
      drv_start <= 1'b0;
      drv_layer <= '0;
      act_we    <= 1'b0;
      act_sel   <= '0;
      act_layer <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef LAYER_SEQ_TIMEOUT_EN
      wdog      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      // Single-cycle strobes default low; only the entering transition raises them.
      drv_start <= 1'b0;
      act_we    <= 1'b0;
      done      <= 1'b0;

      if (abort) begin
        state     <= IDLE;
        layer     <= '0;
        sidx      <= '0;
        vmask     <= '0;
        drv_layer <= '0;
        act_sel   <= '0;
        act_layer <= '0;
        busy      <= 1'b0;
`ifdef LAYER_SEQ_TIMEOUT_EN
        wdog      <= '0;
        err_q     <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            layer <= '0;
            if (run) begin
              state     <= LOAD;
              drv_start <= 1'b1;
              drv_layer <= '0;
              busy      <= 1'b1;
            end
          end

          LOAD: begin
            vmask <= '0;
            state <= WAIT_DRV;
`ifdef LAYER_SEQ_TIMEOUT_EN
            wdog  <= '0;
`endif
          end

          WAIT_DRV: begin
            vmask <= vmask_nxt;
            if (drv_done) begin
              state <= WAIT_UNITS;
`ifdef LAYER_SEQ_TIMEOUT_EN
              wdog  <= '0;
            end else if (wdog_hit) begin
              state <= ERR;
              err_q <= 1'b1;
              busy  <= 1'b0;
            end else begin
              wdog  <= wdog + 16'd1;
`endif
            end
          end

          WAIT_UNITS: begin
            if (vmask_nxt == 4'b1111) begin
              state     <= STORE;
              sidx      <= '0;
              act_we    <= 1'b1;
              act_sel   <= '0;
              act_layer <= layer;
`ifdef LAYER_SEQ_TIMEOUT_EN
            end else if (wdog_hit) begin
              state <= ERR;
              err_q <= 1'b1;
              busy  <= 1'b0;
            end else begin
              vmask <= vmask_nxt;
              wdog  <= wdog + 16'd1;
`else
            end else begin
              vmask <= vmask_nxt;
`endif
            end
          end

          STORE: begin
            if (sidx == 2'd3) begin
              state <= NEXT;
            end else begin
              sidx    <= sidx + 2'd1;
              act_we  <= 1'b1;
              act_sel <= sidx + 2'd1;
            end
          end

          NEXT: begin
            if (layer == LAST_LAYER) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              layer     <= layer + 2'd1;
              drv_layer <= layer + 2'd1;
              drv_start <= 1'b1;
              state     <= LOAD;
            end
          end

          DONE: begin
            state <= IDLE;
          end

          ERR: begin
            if (run) begin
              state     <= LOAD;
              layer     <= '0;
              drv_layer <= '0;
              drv_start <= 1'b1;
              busy      <= 1'b1;
`ifdef LAYER_SEQ_TIMEOUT_EN
              err_q     <= 1'b0;
`endif
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: randomized driver/unit latencies against a cycle-timing
// model of each layer (drv_done edge M, unit edges V_i -> store window starting at max(M+1, V_i)).
`timescale 1ns/1ps
module tb_layer_sequencer;

  localparam int NUM_LAYERS = 3;
  localparam int TB_TIMEOUT = 50;

  typedef enum int {M_NORMAL, M_ABORT, M_RESET} mode_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       abort;
  logic       drv_start;
  logic [1:0] drv_layer;
  logic       drv_done;
  logic [3:0] unit_valid;
  logic       act_we;
  logic [1:0] act_sel;
  logic [1:0] act_layer;
  logic       busy;
  logic       done;
  logic       error;

  int checks   = 0;
  int failures = 0;
  int n_start;
  int n_we;
  int n_done;

  layer_sequencer #(.NUM_LAYERS(NUM_LAYERS), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .abort      (abort),
    .drv_start  (drv_start),
    .drv_layer  (drv_layer),
    .drv_done   (drv_done),
    .unit_valid (unit_valid),
    .act_we     (act_we),
    .act_sel    (act_sel),
    .act_layer  (act_layer),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {drv_start, drv_layer, act_we, act_sel, act_layer, busy, done, error};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    run        = 1'b0;
    abort      = 1'b0;
    drv_done   = 1'b0;
    unit_valid = 4'b0000;
  endtask

  task automatic start_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  // Entered at the negedge right after the edge that raised drv_start (k = 0).
  task automatic do_layer(input int layer_idx, input bit last, input mode_t mode,
                          input bit stagger, input bit spurious, input bit fixed,
                          output bit stopped);
    int dd;
    int m;
    int e;
    int lo;
    int spur_edge;
    int v[4];
    stopped = 1'b0;
    dd = fixed ? 19 : int'($urandom_range(3, 25));
    m  = 1 + dd;
    lo = (dd - 1 < 6) ? dd - 1 : 6;
    for (int i = 0; i < 4; i++)
      v[i] = fixed ? m + 5 : m + int'($urandom_range(0, 12)) - lo;
    if (stagger) begin
      v[0] = m - 1;
      v[1] = m + 1;
      v[2] = m + 2;
      v[3] = m + 3 + int'($urandom_range(0, 4));
    end
    if (mode == M_ABORT && v[3] < m + 4) v[3] = m + 4;
    e = m + 1;
    for (int i = 0; i < 4; i++) if (v[i] > e) e = v[i];
    spur_edge = (e > m + 1) ? m + 1 : e + 1;

    for (int k = 0; k <= e + 4; k++) begin
      n_start += int'(drv_start);
      n_we    += int'(act_we);
      n_done  += int'(done);
      check($sformatf("drv_start L%0d k%0d", layer_idx, k), drv_start, k == 0);
      check($sformatf("drv_layer L%0d k%0d", layer_idx, k), drv_layer, layer_idx);
      check($sformatf("busy L%0d k%0d", layer_idx, k), busy, 1'b1);
      check($sformatf("act_we L%0d k%0d", layer_idx, k), act_we, (k >= e && k <= e + 3));
      check($sformatf("done L%0d k%0d", layer_idx, k), done, 1'b0);
      check($sformatf("error L%0d k%0d", layer_idx, k), error, 1'b0);
      if (k >= e && k <= e + 3) begin
        check($sformatf("act_sel L%0d k%0d", layer_idx, k), act_sel, k - e);
        check($sformatf("act_layer L%0d k%0d", layer_idx, k), act_layer, layer_idx);
      end
      if (mode == M_RESET && k == e + 1) begin
        clear_inputs();
        reset = 1'b0;
        #1;
        check("reset_mid_store outs", outs(), 11'd0);
        tick();
        reset = 1'b1;
        tick();
        check("after_reset outs", outs(), 11'd0);
        stopped = 1'b1;
        return;
      end
      drv_done = (k + 1 == m) || (spurious && k + 1 == spur_edge);
      for (int i = 0; i < 4; i++) unit_valid[i] = (k + 1 == v[i]);
      run   = spurious && (k + 1 == m || k + 1 == e + 1);
      abort = (mode == M_ABORT) && (k + 1 == m + 1);
      tick();
      if (abort) begin
        clear_inputs();
        check("abort busy", busy, 1'b0);
        check("abort drv_start", drv_start, 1'b0);
        check("abort act_we", act_we, 1'b0);
        check("abort done", done, 1'b0);
        stopped = 1'b1;
        return;
      end
    end
    clear_inputs();
    if (last) begin
      n_done += int'(done);
      check($sformatf("final done L%0d", layer_idx), done, 1'b1);
      check($sformatf("final busy L%0d", layer_idx), busy, 1'b0);
      check($sformatf("final drv_start L%0d", layer_idx), drv_start, 1'b0);
      tick();
      check("idle done", done, 1'b0);
      check("idle busy", busy, 1'b0);
    end
  endtask

  task automatic run_layers(input mode_t mode, input int mode_layer, input bit stagger,
                            input bit spurious, input bit fixed);
    bit stopped;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      do_layer(l, l == NUM_LAYERS - 1, (l == mode_layer) ? mode : M_NORMAL,
               stagger, spurious, fixed, stopped);
      if (stopped) break;
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    #1;
    check("reset outs", outs(), 11'd0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("post_reset outs", outs(), 11'd0);

    // abort together with run in IDLE keeps the block idle
    abort = 1'b1;
    run   = 1'b1;
    tick();
    clear_inputs();
    check("abort_run_idle outs", outs(), 11'd0);
    tick();
    check("abort_run_idle busy", busy, 1'b0);

    // directed: drv_done 20 cycles after each drv_start, units 5 cycles later
    n_start = 0;
    n_we    = 0;
    n_done  = 0;
    start_run();
    run_layers(M_NORMAL, -1, 1'b0, 1'b0, 1'b1);
    check("directed drv_start count", n_start, 3);
    check("directed act_we count", n_we, 12);
    check("directed done count", n_done, 1);

    // staggered unit_valid with stray run/drv_done while busy
    start_run();
    run_layers(M_NORMAL, -1, 1'b1, 1'b1, 1'b0);

    // abort in WAIT_UNITS of layer 1, then a clean restart from layer 0
    n_done = 0;
    start_run();
    run_layers(M_ABORT, 1, 1'b0, 1'b0, 1'b0);
    repeat (5) begin
      tick();
      n_done += int'(done);
      check("post_abort busy", busy, 1'b0);
    end
    check("post_abort done count", n_done, 0);
    start_run();
    run_layers(M_NORMAL, -1, 1'b0, 1'b0, 1'b0);

    // asynchronous reset during STORE of the last layer, then a full run
    start_run();
    run_layers(M_RESET, NUM_LAYERS - 1, 1'b0, 1'b0, 1'b0);
    start_run();
    run_layers(M_NORMAL, -1, 1'b0, 1'b0, 1'b0);

    repeat (6) begin
      start_run();
      run_layers(M_NORMAL, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef LAYER_SEQ_TIMEOUT_EN
    // drv_done withheld: error rises 50 cycles after the drv_start pulse ends
    start_run();
    check("wdog drv_start", drv_start, 1'b1);
    for (int k = 1; k <= TB_TIMEOUT; k++) begin
      tick();
      check($sformatf("wdog quiet k%0d", k), error, 1'b0);
    end
    tick();
    check("wdog error", error, 1'b1);
    check("wdog busy", busy, 1'b0);
    start_run();
    run_layers(M_NORMAL, -1, 1'b0, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
